// File: rtl/switch_control.sv
`default_nettype none
// ============================================================================
// Module   : switch_control
// Purpose  : Central allocation controller of the Phoenix router. Picks one
//            pending header per pass with round-robin priority, presents its
//            destination to the routing mechanism, and if the returned output
//            is free, grants the connection and records it in the crossbar
//            tables. Outputs are released when the owning input stops sending.
// Ports    : i_clk        - clock, rising edge
//            i_rst        - asynchronous active-high reset
//            i_h          - per-input header-pending request
//            i_data       - head flit of each input, input k at [k*TAM_FLIT +: TAM_FLIT]
//            i_sender     - per-input "packet still transmitting"
//            i_route_port - one-hot output port from the routing mechanism
//            o_route_dest - destination presented to the routing mechanism
//            o_ack_h      - header-accepted pulse per input
//            o_free       - per-output availability
//            o_tab_in     - per output, 3-bit index of the input driving it
//            o_tab_out    - per input, 3-bit index of the output it uses
// Revision : 1.0 - initial release
// ============================================================================
module switch_control #(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int          NPORT    = 5,
  parameter int          TAM_FLIT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NPORT-1:0]          i_h,
  input  logic [NPORT*TAM_FLIT-1:0] i_data,
  input  logic [NPORT-1:0]          i_sender,
  input  logic [NPORT-1:0]          i_route_port,
  output logic [TAM_FLIT-1:0]       o_route_dest,
  output logic [NPORT-1:0]          o_ack_h,
  output logic [NPORT-1:0]          o_free,
  output logic [NPORT*3-1:0]        o_tab_in,
  output logic [NPORT*3-1:0]        o_tab_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ROUTE = 3'd2,
    S_CHECK = 3'd3,
    S_GRANT = 3'd4
  } state_t;

  // The router address is consumed by the external routing mechanism; it is
  // kept here so the parameter list matches the rest of the router.
  logic unused_addr;
  assign unused_addr = ^ADDRESS;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic [NPORT-1:0] port_oh_q, port_oh_d;
  logic [NPORT-1:0] free_q, free_d;
  logic [2:0]       tab_in_q  [NPORT];
  logic [2:0]       tab_in_d  [NPORT];
  logic [2:0]       tab_out_q [NPORT];
  logic [2:0]       tab_out_d [NPORT];

  logic             arb_found;
  logic [2:0]       arb_winner;
  logic [2:0]       port_idx;
  logic             port_valid;

  // Round-robin search starting one past the last winner, wrapping at NPORT.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    for (int i = 1; i <= NPORT; i++) begin
      int cand;
      cand = int'(last_q) + i;
      if (cand >= NPORT) cand = cand - NPORT;
      if (!arb_found && i_h[cand]) begin
        arb_found  = 1'b1;
        arb_winner = 3'(cand);
      end
    end
  end

  // Binary index of the captured one-hot port; only trusted when one-hot.
  always_comb begin
    port_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (port_oh_q[i]) port_idx = 3'(i);
    end
    port_valid = $onehot(port_oh_q);
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    port_oh_d = port_oh_q;
    free_d    = free_q;
    tab_in_d  = tab_in_q;
    tab_out_d = tab_out_q;

    // Release runs every cycle regardless of the FSM. It only touches busy
    // outputs, while a grant only targets free ones, so the two never collide.
    for (int o = 0; o < NPORT; o++) begin
      if (!free_q[o] && !i_sender[tab_in_q[o]]) free_d[o] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (|i_h) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          sel_d   = arb_winner;
          last_d  = arb_winner;
          state_d = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        port_oh_d = i_route_port;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        // Uses the pre-edge free flag: a release landing this same edge
        // does not produce a grant; the requester retries on a later pass.
        if (port_valid && free_q[port_idx]) state_d = S_GRANT;
        else                                state_d = S_IDLE;
      end
      S_GRANT: begin
        free_d[port_idx]   = 1'b0;
        tab_in_d[port_idx] = sel_q;
        tab_out_d[sel_q]   = port_idx;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      last_q    <= 3'(NPORT - 1);
      port_oh_q <= '0;
      free_q    <= '1;
      for (int i = 0; i < NPORT; i++) begin
        tab_in_q[i]  <= '0;
        tab_out_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      port_oh_q <= port_oh_d;
      free_q    <= free_d;
      for (int i = 0; i < NPORT; i++) begin
        tab_in_q[i]  <= tab_in_d[i];
        tab_out_q[i] <= tab_out_d[i];
      end
    end
  end

  // Outputs decoded from registered state only; no path from i_h.
  always_comb begin
    o_ack_h      = '0;
    o_route_dest = '0;
    if (state_q == S_GRANT) o_ack_h[sel_q] = 1'b1;
    if (state_q == S_ROUTE) o_route_dest = i_data[int'(sel_q)*TAM_FLIT +: TAM_FLIT];
  end

  assign o_free = free_q;

  generate
    for (genvar g = 0; g < NPORT; g++) begin : g_tab
      assign o_tab_in[g*3 +: 3]  = tab_in_q[g];
      assign o_tab_out[g*3 +: 3] = tab_out_q[g];
    end
  endgenerate

endmodule
`default_nettype wire
